axi4_lite_master: RTL and testbench

Host-side AXI4-Lite master that turns a simple one-at-a-time command interface into AXI4-Lite write and read transactions. It sits directly upstream of axi4_lite_slave and drives its aw/w/b/ar/r channels. It is used by the LSTM host sequencer and benches to load weights and read back results. Exactly one transaction is outstanding at a time, and every command returns exactly one response.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_master.sv | 234 +++++++++++++++++++++++
 tb/tb_axi4_lite_master.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes, prot default and master state encoding
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } mst_state_e;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - one-outstanding AXI4-Lite master driven by a cmd/rsp handshake interface
//
// Purpose: each accepted command becomes one AXI4-Lite write (aw+w, then b) or
// read (ar, then r) and produces exactly one response on the rsp interface.
// Optional AXI_TIMEOUT_EN: abort any channel wait after TIMEOUT_CYCLES cycles
// and answer with SLVERR.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cmd_*               command in (valid/ready, write, addr, data, strb)
//   rsp_*               response out (valid/ready, write, data, resp)
//   aw*/w*/b*/ar*/r*    AXI4-Lite master channels
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  mst_state_e state_q, state_d;

  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_write_q, rsp_write_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

`ifdef AXI_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        waiting;
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  // cmd_ready is the only combinational output; reset masks it immediately.
  assign cmd_ready = rst && (state_q == IDLE);
  assign awprot    = PROT_DEFAULT;
  assign arprot    = PROT_DEFAULT;
  assign awvalid   = awvalid_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = awaddr_q;
  assign araddr    = araddr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_data;
            wstrb_d   = cmd_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // aw and w retire independently; a dropped valid marks its channel done.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          rsp_write_d = 1'b1;
          rsp_data_d  = '0;
          rsp_resp_d  = bresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rvalid) begin
          rready_d    = 1'b0;
          rsp_write_d = 1'b0;
          rsp_data_d  = rdata;
          rsp_resp_d  = rresp;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXI_TIMEOUT_EN
    waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
              (state_q == RD_REQ) || (state_q == RD_DATA);
    // A handshake that completes this cycle wins over the abort.
    if (waiting && (state_d == state_q) && (tmo_cnt_q == TMO_LAST)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_write_d = (state_q == WR_REQ) || (state_q == WR_RESP);
      rsp_data_d  = '0;
      rsp_resp_d  = RESP_SLVERR;
      rsp_valid_d = 1'b1;
      state_d     = RSP;
    end
    tmo_cnt_d = ((state_d != state_q) || !waiting) ? 32'd0 : tmo_cnt_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_TIMEOUT_EN
      tmo_cnt_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
`ifdef AXI_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - scoreboard bench for axi4_lite_master with a behavioural AXI4-Lite slave
module tb_axi4_lite_master;

`ifdef AXI_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0, rready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- behavioural slave ----------------
  logic [31:0] smem [16];
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit          ar_never = 0, r_ovr = 0;
  logic [31:0] r_ovr_data = '0;
  logic [1:0]  r_ovr_resp = 2'b00, b_resp_cfg = 2'b00;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit          got_aw = 0, got_w = 0, pend_b = 0, pend_r = 0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_rdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [1:0]  s_rresp = 2'b00;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0, cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0;
    end else begin
      if (awvalid && awready) begin got_aw = 1; s_awaddr = awaddr; aw_hs++; aw_hs_cyc = cyc; end
      if (wvalid && wready) begin got_w = 1; s_wdata = wdata; s_wstrb = wstrb; w_hs++; w_hs_cyc = cyc; end
      if (bvalid && bready) begin pend_b = 0; b_hs++; end
      if (got_aw && got_w) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) smem[s_awaddr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
        got_aw = 0; got_w = 0; pend_b = 1;
      end
      if (rvalid && rready) pend_r = 0;
      if (arvalid && arready) begin
        ar_hs++;
        pend_r  = 1;
        s_rdata = r_ovr ? r_ovr_data : smem[araddr[5:2]];
        s_rresp = r_ovr ? r_ovr_resp : 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_cnt >= aw_delay); if (aw_cnt < aw_delay) aw_cnt++; end
    else begin awready = 0; aw_cnt = 0; end
    if (wvalid) begin wready = (w_cnt >= w_delay); if (w_cnt < w_delay) w_cnt++; end
    else begin wready = 0; w_cnt = 0; end
    if (arvalid && !ar_never) begin arready = (ar_cnt >= ar_delay); if (ar_cnt < ar_delay) ar_cnt++; end
    else begin arready = 0; ar_cnt = 0; end
    bvalid = pend_b;
    bresp  = pend_b ? b_resp_cfg : 2'b00;
    rvalid = pend_r;
    rdata  = pend_r ? s_rdata : 32'h0;
    rresp  = pend_r ? s_rresp : 2'b00;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [16];
  rsp_t        exp_q [$];

  task automatic expect_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    rsp_t e;
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
      e = '{w: 1'b1, d: 32'h0, r: b_resp_cfg};
    end else begin
      e = r_ovr ? '{w: 1'b0, d: r_ovr_data, r: r_ovr_resp} : '{w: 1'b0, d: ref_mem[a[5:2]], r: 2'b00};
    end
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output bit ok);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_data = d; cmd_strb = s;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    ok = cmd_ready;
    if (ok) @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic get_rsp(output rsp_t got, output bit ok);
    int n = 0;
    rsp_ready = 1;
    while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
    ok  = rsp_valid;
    got = '{w: rsp_write, d: rsp_data, r: rsp_resp};
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [31:0] vec;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec = {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, cmd_ready,
           awprot, arprot, rsp_resp, 12'h0};
    total++; if (vec !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", vec); end
    total++; if ({awaddr, araddr} !== 64'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", {awaddr, araddr}); end
    total++; if ({wdata, wstrb, rsp_data} !== 68'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {wdata, wstrb, rsp_data}); end
    rst = 1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write_read;
    rsp_t got, e; bit ok, ok2;
    expect_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF);
    send_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL wr_rsp got=%h exp=%h", got, e); end
    total++; if ({s_awaddr, s_wdata, s_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF})
      begin bad++; $display("FAIL wr_bus got=%h exp=%h", {s_awaddr, s_wdata, s_wstrb}, {32'h10, 32'hDEADBEEF, 4'hF}); end
    expect_cmd(0, 32'h10, 32'h0, 4'h0);
    send_cmd(0, 32'h10, 32'h0, 4'h0, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL rd_rsp got=%h exp=%h", got, e); end
    expect_cmd(1, 32'h14, 32'h11223344, 4'hF);
    send_cmd(1, 32'h14, 32'h11223344, 4'hF, ok); get_rsp(got, ok2); void'(exp_q.pop_front());
    expect_cmd(1, 32'h14, 32'hAABBCCDD, 4'b0101);
    send_cmd(1, 32'h14, 32'hAABBCCDD, 4'b0101, ok); get_rsp(got, ok2); void'(exp_q.pop_front());
    total++; if (s_wstrb !== 4'b0101) begin bad++; $display("FAIL wr_strb got=%b exp=0101", s_wstrb); end
    expect_cmd(0, 32'h14, 32'h0, 4'h0);
    send_cmd(0, 32'h14, 32'h0, 4'h0, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e || got.d !== 32'h11BB33DD)
      begin bad++; $display("FAIL rd_strb got=%h exp=%h", got, e); end
  endtask

  task automatic test_w_before_aw;
    rsp_t got, e; bit ok, ok2, saw_w_first = 0;
    int aw0 = aw_hs, w0 = w_hs, b0 = b_hs;
    aw_delay = 3; w_delay = 0;
    expect_cmd(1, 32'h20, 32'hCAFE0001, 4'hF);
    send_cmd(1, 32'h20, 32'hCAFE0001, 4'hF, ok);
    for (int i = 0; i < 30; i++) begin
      if (!wvalid && awvalid) saw_w_first = 1;
      if (!wvalid && !awvalid) break;
      @(negedge clk);
    end
    get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL wfirst_rsp got=%h exp=%h", got, e); end
    total++; if (saw_w_first !== 1'b1) begin bad++; $display("FAIL wfirst_order got=%b exp=1", saw_w_first); end
    total++; if (aw_hs_cyc - w_hs_cyc !== 3) begin bad++; $display("FAIL wfirst_gap got=%0d exp=3", aw_hs_cyc - w_hs_cyc); end
    total++; if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1})
      begin bad++; $display("FAIL wfirst_hs got=%0d/%0d/%0d exp=1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
    aw_delay = 0;
  endtask

  task automatic test_slverr;
    rsp_t got, e; bit ok, ok2;
    r_ovr = 1; r_ovr_data = 32'h1234; r_ovr_resp = 2'b10;
    expect_cmd(0, 32'h24, 32'h0, 4'h0);
    send_cmd(0, 32'h24, 32'h0, 4'h0, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL rd_slverr got=%h exp=%h", got, e); end
    r_ovr = 0; b_resp_cfg = 2'b11;
    expect_cmd(1, 32'h28, 32'h55AA55AA, 4'hF);
    send_cmd(1, 32'h28, 32'h55AA55AA, 4'hF, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL wr_decerr got=%h exp=%h", got, e); end
    b_resp_cfg = 2'b00;
  endtask

  task automatic test_hold;
    rsp_t got, e, snap; bit ok, ok2; int n = 0; int aw0;
    expect_cmd(0, 32'h10, 32'h0, 4'h0);
    send_cmd(0, 32'h10, 32'h0, 4'h0, ok);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    snap = '{w: rsp_write, d: rsp_data, r: rsp_resp};
    e = exp_q.pop_front();
    total++; if (!ok || !rsp_valid || snap !== e) begin bad++; $display("FAIL hold_rsp got=%h exp=%h", snap, e); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h2C; cmd_data = 32'h0BADF00D; cmd_strb = 4'hF;
    aw0 = aw_hs;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (!rsp_valid || {rsp_write, rsp_data, rsp_resp} !== e || cmd_ready !== 1'b0)
        begin bad++; $display("FAIL hold_stable cyc=%0d got=%b/%h/%b exp=1/%h/0", i, rsp_valid, {rsp_write, rsp_data, rsp_resp}, e, cmd_ready); end
    end
    expect_cmd(1, 32'h2C, 32'h0BADF00D, 4'hF);
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    total++; if ({rsp_valid, cmd_ready, aw_hs - aw0} !== {1'b0, 1'b1, 32'd0})
      begin bad++; $display("FAIL hold_release got=%b/%b/%0d exp=0/1/0", rsp_valid, cmd_ready, aw_hs - aw0); end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b exp=0", cmd_ready); end
    get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok2 || got !== e) begin bad++; $display("FAIL hold_next got=%h exp=%h", got, e); end
  endtask

  task automatic test_reset_mid;
    rsp_t got, e; bit ok, ok2, seen = 0;
    aw_delay = 20; w_delay = 20;
    send_cmd(1, 32'h30, 32'h77777777, 4'hF, ok);
    total++; if ({ok, awvalid, wvalid} !== 3'b111) begin bad++; $display("FAIL rmid_pre got=%b exp=111", {ok, awvalid, wvalid}); end
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    total++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0)
      begin bad++; $display("FAIL rmid_drop got=%b exp=000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
    rst = 1;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_idle got=%b exp=1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin if (rsp_valid) seen = 1; @(negedge clk); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_norsp got=%b exp=0", seen); end
    expect_cmd(0, 32'h30, 32'h0, 4'h0);
    send_cmd(0, 32'h30, 32'h0, 4'h0, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL rmid_read got=%h exp=%h", got, e); end
  endtask

  task automatic test_timeout;
    rsp_t got, e; bit ok, ok2; int ar_high = 0;
    ar_never = 1;
    send_cmd(0, 32'h04, 32'h0, 4'h0, ok);
    for (int i = 0; i < 120; i++) begin
      if (!arvalid || rsp_valid) break;
      ar_high++;
      @(negedge clk);
    end
`ifdef AXI_TIMEOUT_EN
    total++; if (ar_high < TO - 1 || ar_high > TO + 2)
      begin bad++; $display("FAIL tmo_len got=%0d exp=%0d", ar_high, TO); end
    e = '{w: 1'b0, d: 32'h0, r: 2'b10};
    get_rsp(got, ok2);
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL tmo_rsp got=%h exp=%h", got, e); end
    ar_never = 0;
`else
    total++; if (ar_high < 100 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL tmo_wait got=%0d/%b exp=>=100/0", ar_high, rsp_valid); end
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    ar_never = 0;
`endif
    expect_cmd(0, 32'h10, 32'h0, 4'h0);
    send_cmd(0, 32'h10, 32'h0, 4'h0, ok); get_rsp(got, ok2); e = exp_q.pop_front();
    total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL tmo_after got=%h exp=%h", got, e); end
  endtask

  task automatic test_back_to_back;
    rsp_t got, e; bit ok, ok2;
    logic w; logic [31:0] a, d; logic [3:0] s;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      expect_cmd(w, a, d, s);
      send_cmd(w, a, d, s, ok); get_rsp(got, ok2); e = exp_q.pop_front();
      total++; if (!ok || !ok2 || got !== e) begin bad++; $display("FAIL b2b_%0d got=%h exp=%h", i, got, e); end
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_slverr();
    test_hold();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
